fan_cfg_tx: RTL

FAN_CFG_TX -- requirements
Module: fan_cfg_tx

---
 rtl/fan_cfg_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/fan_cfg_tx.sv
// Byte transmitter feeding the fan controller: a small FIFO of {cfg, byte}
// entries drained by an IDLE/STROBE/GAP sequencer that paces one-clock strobes.
module fan_cfg_tx #(
    parameter int GAP_CYCLES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic       tx_is_cfg,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       config_enable,
    output logic       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } state_t;

    state_t          state;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nxt;
    logic [3:0]      gap_cnt;
    logic            push;
    logic            pop;

    assign tx_ready = (count != FULL_CNT);
    assign push     = tx_valid && tx_ready;
    assign pop      = (state == IDLE) && (count != '0);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {tx_is_cfg, tx_data};
    end

    // busy is computed from the post-edge state and count so it can stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            gap_cnt       <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            config_enable <= 1'b0;
            busy          <= 1'b0;
        end else begin
            count <= count_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;

            case (state)
                IDLE: begin
                    if (pop) begin
                        rd_ptr        <= rd_ptr + PTR_ONE;
                        data_out      <= mem[rd_ptr][7:0];
                        config_enable <= mem[rd_ptr][8];
                        data_valid    <= 1'b1;
                        busy          <= 1'b1;
                        state         <= STROBE;
                    end else begin
                        config_enable <= 1'b0;
                        data_valid    <= 1'b0;
                        busy          <= (count_nxt != '0);
                    end
                end
                STROBE: begin
                    data_valid <= 1'b0;
                    gap_cnt    <= '0;
                    busy       <= 1'b1;
                    state      <= GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_cnt == GAP_LAST) begin
                        config_enable <= 1'b0;
                        busy          <= (count_nxt != '0);
                        state         <= IDLE;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    data_valid    <= 1'b0;
                    config_enable <= 1'b0;
                    busy          <= (count_nxt != '0);
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
